// File: rtl/ooo_mem_responder_if.sv
// Tagged read request / response bundle between the ROB (master) and the
// out-of-order memory responder (slave).
interface ooo_mem_responder_if #(
  parameter int SWIDTH = 4,
  parameter int AWIDTH = 40,
  parameter int DWIDTH = 32
);
  logic              mem_req_val;
  logic [AWIDTH-1:0] mem_req_addr;
  logic [SWIDTH-1:0] mem_req_ID;
  logic              mem_rsp_val;
  logic [SWIDTH-1:0] mem_rsp_ID;
  logic [DWIDTH-1:0] mem_rsp_data;

  modport master (
    output mem_req_val, mem_req_addr, mem_req_ID,
    input  mem_rsp_val, mem_rsp_ID, mem_rsp_data
  );

  modport slave (
    input  mem_req_val, mem_req_addr, mem_req_ID,
    output mem_rsp_val, mem_rsp_ID, mem_rsp_data
  );
endinterface

// File: rtl/ooo_mem_responder.sv
// Memory model behind the ROB: holds each tagged read in its own slot for a fixed
// or LFSR-driven latency, then returns it through a round-robin arbiter, one per cycle.
module ooo_mem_responder #(
  parameter int          ROB_SIZE  = 16,
  parameter int          SWIDTH    = 4,
  parameter int          AWIDTH    = 40,
  parameter int          DWIDTH    = 32,
  parameter int          LAT_WIDTH = 4,
  parameter logic [31:0] LFSR_SEED = 32'h1d76993a
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_fix_lat_en,
  input  logic [LAT_WIDTH-1:0] cfg_fix_lat,
  ooo_mem_responder_if.slave   mem,
  output logic [SWIDTH:0]      busy_cnt,
  output logic                 err_dup_id
);

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  typedef logic [SWIDTH-1:0]    id_t;
  typedef logic [LAT_WIDTH-1:0] lat_t;

  // Slot storage
  logic [ROB_SIZE-1:0] slot_valid_q, slot_valid_d;
  logic [AWIDTH-1:0]   slot_addr_q [ROB_SIZE];
  logic [AWIDTH-1:0]   slot_addr_d [ROB_SIZE];
  lat_t                slot_cnt_q  [ROB_SIZE];
  lat_t                slot_cnt_d  [ROB_SIZE];

  logic [31:0]         lfsr_q, lfsr_d;
  id_t                 ptr_q, ptr_d;
  logic                rsp_val_q, rsp_val_d;
  id_t                 rsp_id_q, rsp_id_d;
  logic [DWIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [SWIDTH:0]     busy_q, busy_d;
  logic                err_q, err_d;

  logic [ROB_SIZE-1:0] eligible;
  logic                grant_val;
  id_t                 grant_id;
  id_t                 scan_id;
  logic                req_hit;
  logic                accept;
  logic                dup;
  lat_t                new_lat;

  // A slot being granted this cycle is still valid, so a request for it is a duplicate.
  assign req_hit = slot_valid_q[mem.mem_req_ID];
  assign accept  = mem.mem_req_val && !req_hit;
  assign dup     = mem.mem_req_val && req_hit;
  assign new_lat = cfg_fix_lat_en ? cfg_fix_lat : lfsr_q[LAT_WIDTH-1:0];

  always_comb begin
    eligible = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      eligible[i] = slot_valid_q[i] && (slot_cnt_q[i] == '0);
    end
  end

  // Round-robin search from ptr_q; the id_t addition wraps because ROB_SIZE == 2**SWIDTH.
  always_comb begin
    grant_val = 1'b0;
    grant_id  = '0;
    scan_id   = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      scan_id = ptr_q + id_t'(i);
      if (!grant_val && eligible[scan_id]) begin
        grant_val = 1'b1;
        grant_id  = scan_id;
      end
    end
  end

  // NOTE: every variable gets its default at the top of a combinational block, so
  // no path can leave a value unassigned and infer a latch.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_addr_d  = slot_addr_q;
    for (int i = 0; i < ROB_SIZE; i++) begin
      slot_cnt_d[i] = (slot_valid_q[i] && slot_cnt_q[i] != '0) ? slot_cnt_q[i] - lat_t'(1)
                                                                : slot_cnt_q[i];
    end
    if (grant_val) begin
      slot_valid_d[grant_id] = 1'b0;
    end
    if (accept) begin
      slot_valid_d[mem.mem_req_ID] = 1'b1;
      slot_addr_d[mem.mem_req_ID]  = mem.mem_req_addr;
      slot_cnt_d[mem.mem_req_ID]   = new_lat;
    end
  end

  always_comb begin
    lfsr_d     = accept ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 32'h0)) : lfsr_q;
    ptr_d      = grant_val ? grant_id + id_t'(1) : ptr_q;
    rsp_val_d  = grant_val;
    rsp_id_d   = grant_val ? grant_id : rsp_id_q;
    rsp_data_d = grant_val ? DWIDTH'(slot_addr_q[grant_id]) : rsp_data_q;
    busy_d     = busy_q + (SWIDTH+1)'(accept) - (SWIDTH+1)'(grant_val);
    err_d      = err_q | dup;
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid_q <= '0;
      // NOTE: slot address/counter storage is reset as well, so the first response
      // after reset can never expose stale contents.
      for (int i = 0; i < ROB_SIZE; i++) begin
        slot_addr_q[i] <= '0;
        slot_cnt_q[i]  <= '0;
      end
      lfsr_q     <= LFSR_SEED;
      ptr_q      <= '0;
      rsp_val_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_addr_q  <= slot_addr_d;
      slot_cnt_q   <= slot_cnt_d;
      lfsr_q       <= lfsr_d;
      ptr_q        <= ptr_d;
      rsp_val_q    <= rsp_val_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign mem.mem_rsp_val  = rsp_val_q;
  assign mem.mem_rsp_ID   = rsp_id_q;
  assign mem.mem_rsp_data = rsp_data_q;
  assign busy_cnt         = busy_q;
  assign err_dup_id       = err_q;

endmodule

// File: tb/tb_ooo_mem_responder.sv
// Directed scenarios plus random traffic for ooo_mem_responder, checked every cycle
// against a slot/due-time reference model.
module tb_ooo_mem_responder;
  localparam int          ROB_SIZE  = 16;
  localparam int          SWIDTH    = 4;
  localparam int          AWIDTH    = 40;
  localparam int          DWIDTH    = 32;
  localparam int          LAT_WIDTH = 4;
  localparam logic [31:0] SEED      = 32'h1d76993a;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 cfg_fix_lat_en;
  logic [LAT_WIDTH-1:0] cfg_fix_lat;
  logic [SWIDTH:0]      busy_cnt;
  logic                 err_dup_id;

  ooo_mem_responder_if #(.SWIDTH(SWIDTH), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) mem_if ();

  ooo_mem_responder #(
    .ROB_SIZE(ROB_SIZE), .SWIDTH(SWIDTH), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH),
    .LAT_WIDTH(LAT_WIDTH), .LFSR_SEED(SEED)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_fix_lat_en (cfg_fix_lat_en),
    .cfg_fix_lat    (cfg_fix_lat),
    .mem            (mem_if.slave),
    .busy_cnt       (busy_cnt),
    .err_dup_id     (err_dup_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a slot becomes eligible at an absolute edge number (due time).
  bit                m_valid [ROB_SIZE];
  logic [AWIDTH-1:0] m_addr  [ROB_SIZE];
  int                m_due   [ROB_SIZE];
  int                m_ptr;
  int                edge_n;
  logic [31:0]       m_lfsr;
  bit                m_err;
  bit                m_rsp_val;
  int                m_rsp_id;
  logic [DWIDTH-1:0] m_rsp_data;

  int                rsp_ids   [$];
  logic [DWIDTH-1:0] rsp_datas [$];
  int                rsp_edges [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ROB_SIZE; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = '0;
      m_due[i]   = 0;
    end
    m_ptr      = 0;
    edge_n     = 0;
    m_lfsr     = SEED;
    m_err      = 1'b0;
    m_rsp_val  = 1'b0;
    m_rsp_id   = 0;
    m_rsp_data = '0;
  endfunction

  function automatic int model_busy();
    int n = 0;
    for (int i = 0; i < ROB_SIZE; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  // Applies one clock edge to the model using the inputs currently driven.
  function automatic void model_edge();
    int g = -1;
    int id;
    for (int k = 0; k < ROB_SIZE; k++) begin
      int s = (m_ptr + k) % ROB_SIZE;
      if (g < 0 && m_valid[s] && edge_n >= m_due[s]) g = s;
    end
    if (mem_if.mem_req_val) begin
      id = int'(mem_if.mem_req_ID);
      if (m_valid[id]) begin
        m_err = 1'b1;
      end else begin
        m_valid[id] = 1'b1;
        m_addr[id]  = mem_if.mem_req_addr;
        m_due[id]   = edge_n + 1 + int'(cfg_fix_lat_en ? cfg_fix_lat : m_lfsr[3:0]);
        m_lfsr      = lfsr_next(m_lfsr);
      end
    end
    m_rsp_val = (g >= 0);
    if (g >= 0) begin
      m_valid[g] = 1'b0;
      m_rsp_id   = g;
      m_rsp_data = m_addr[g][DWIDTH-1:0];
      m_ptr      = (g + 1) % ROB_SIZE;
    end
    edge_n++;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("rsp_val", 64'(mem_if.mem_rsp_val), 64'(m_rsp_val));
    check("rsp_id", 64'(mem_if.mem_rsp_ID), 64'(m_rsp_id));
    check("rsp_data", 64'(mem_if.mem_rsp_data), 64'(m_rsp_data));
    check("busy_cnt", 64'(busy_cnt), 64'(model_busy()));
    check("err_dup_id", 64'(err_dup_id), 64'(m_err));
    if (mem_if.mem_rsp_val) begin
      rsp_ids.push_back(int'(mem_if.mem_rsp_ID));
      rsp_datas.push_back(mem_if.mem_rsp_data);
      rsp_edges.push_back(edge_n);
    end
  endtask

  task automatic set_idle();
    mem_if.mem_req_val  = 1'b0;
    mem_if.mem_req_ID   = '0;
    mem_if.mem_req_addr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int id, input logic [AWIDTH-1:0] addr);
    mem_if.mem_req_val  = 1'b1;
    mem_if.mem_req_ID   = SWIDTH'(id);
    mem_if.mem_req_addr = addr;
    tick();
    set_idle();
  endtask

  task automatic clear_log();
    rsp_ids.delete();
    rsp_datas.delete();
    rsp_edges.delete();
  endtask

  // Reset is asserted away from the clock edge and held across one rising edge.
  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    #2;
    model_reset();
    check("rst_busy", 64'(busy_cnt), 64'(0));
    check("rst_rsp_val", 64'(mem_if.mem_rsp_val), 64'(0));
    check("rst_err", 64'(err_dup_id), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_random(input int cycles);
    int max_busy = 0;
    for (int n = 0; n < cycles; n++) begin
      int start = int'($urandom_range(0, ROB_SIZE - 1));
      if ($urandom_range(0, 3) == 0) begin
        cfg_fix_lat_en = ($urandom_range(0, 4) == 0);
        cfg_fix_lat    = LAT_WIDTH'($urandom);
      end
      if ($urandom_range(0, 9) < 7) begin
        for (int k = 0; k < ROB_SIZE; k++) begin
          int s = (start + k) % ROB_SIZE;
          if (!mem_if.mem_req_val && !m_valid[s]) begin
            mem_if.mem_req_val  = 1'b1;
            mem_if.mem_req_ID   = SWIDTH'(s);
            mem_if.mem_req_addr = {AWIDTH'($urandom) << 4, 4'(s)} >> 4 | AWIDTH'(s);
          end
        end
      end
      tick();
      set_idle();
      if (int'(busy_cnt) > max_busy) max_busy = int'(busy_cnt);
      if (mem_if.mem_rsp_val)
        check("t5_data_tag", 64'(mem_if.mem_rsp_data[3:0]), 64'(mem_if.mem_rsp_ID));
    end
    check("t5_err_clear", 64'(err_dup_id), 64'(0));
    check("t5_busy_max", 64'(max_busy <= ROB_SIZE), 64'(1));
  endtask

  initial begin
    int exp_ids[4];
    bit [ROB_SIZE-1:0] seen;
    int lat_seen;
    logic [DWIDTH-1:0] data7;

    set_idle();
    cfg_fix_lat_en = 1'b1;
    cfg_fix_lat    = '0;
    #1;
    do_reset();

    // T1: fixed latency 3 responds exactly four edges after the accepting edge
    cfg_fix_lat = 4'd3;
    send(5, 40'h12345);
    check("t1_busy_one", 64'(busy_cnt), 64'(1));
    idle(3);
    check("t1_not_early", 64'(mem_if.mem_rsp_val), 64'(0));
    idle(1);
    check("t1_val", 64'(mem_if.mem_rsp_val), 64'(1));
    check("t1_id", 64'(mem_if.mem_rsp_ID), 64'(5));
    check("t1_data", 64'(mem_if.mem_rsp_data), 64'h12345);
    check("t1_busy_zero", 64'(busy_cnt), 64'(0));
    idle(1);
    check("t1_single_pulse", 64'(mem_if.mem_rsp_val), 64'(0));

    // T2: latency 0, back-to-back requests return in arrival order with no gaps
    do_reset();
    cfg_fix_lat = 4'd0;
    clear_log();
    send(3, 40'h3);
    send(1, 40'h1);
    send(2, 40'h2);
    idle(3);
    check("t2_count", 64'(rsp_ids.size()), 64'(3));
    if (rsp_ids.size() == 3) begin
      check("t2_first", 64'(rsp_ids[0]), 64'(3));
      check("t2_second", 64'(rsp_ids[1]), 64'(1));
      check("t2_third", 64'(rsp_ids[2]), 64'(2));
      check("t2_no_gaps", 64'(rsp_edges[2] - rsp_edges[0]), 64'(2));
    end

    // T3: move ptr to 15, then make 14,15,0,1 eligible on the same cycle
    do_reset();
    send(14, 40'hE);
    idle(2);
    clear_log();
    cfg_fix_lat = 4'd11; send(14, 40'hAE);
    cfg_fix_lat = 4'd10; send(15, 40'hAF);
    cfg_fix_lat = 4'd9;  send(0, 40'hA0);
    cfg_fix_lat = 4'd8;  send(1, 40'hA1);
    idle(16);
    exp_ids = '{15, 0, 1, 14};
    check("t3_count", 64'(rsp_ids.size()), 64'(4));
    if (rsp_ids.size() == 4)
      for (int i = 0; i < 4; i++) check($sformatf("t3_grant%0d", i), 64'(rsp_ids[i]), 64'(exp_ids[i]));

    // T4: fill every tag, then duplicates (one on a slot being granted that edge)
    do_reset();
    cfg_fix_lat = 4'd15;
    clear_log();
    for (int i = 0; i < ROB_SIZE; i++) send(i, {8'hC5, 16'h0, 16'(i * 32'h1111)});
    check("t4_full", 64'(busy_cnt), 64'(16));
    send(0, 40'hFF_FFFF_FFFF);
    check("t4_dup_err", 64'(err_dup_id), 64'(1));
    check("t4_busy_after_dup", 64'(busy_cnt), 64'(15));
    send(7, 40'hEE_EEEE_EEEE);
    idle(40);
    check("t4_rsp_count", 64'(rsp_ids.size()), 64'(16));
    seen  = '0;
    data7 = '0;
    foreach (rsp_ids[i]) begin
      seen[rsp_ids[i]] = 1'b1;
      if (rsp_ids[i] == 7) data7 = rsp_datas[i];
    end
    check("t4_all_ids", 64'(seen), 64'hFFFF);
    check("t4_id7_data", 64'(data7), 64'h0000_7777);
    check("t4_err_sticky", 64'(err_dup_id), 64'(1));

    // T5: random latency, random free tags
    do_reset();
    run_random(4000);

    // T6: reset with slots in flight; nothing may come out afterwards
    do_reset();
    cfg_fix_lat_en = 1'b0;
    for (int i = 2; i < 7; i++) send(i, 40'(i));
    do_reset();
    check("t6_busy_zero", 64'(busy_cnt), 64'(0));
    clear_log();
    idle(20);
    check("t6_no_rsp", 64'(rsp_ids.size()), 64'(0));
    // First latency after reset comes from the seed's low nibble (0xA): 1 + 10 edges.
    send(9, 40'h99);
    lat_seen = -1;
    for (int k = 1; k <= 20 && lat_seen < 0; k++) begin
      tick();
      if (mem_if.mem_rsp_val) lat_seen = k;
    end
    check("t6_first_lat", 64'(lat_seen), 64'(11));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
